// File: rtl/instr_reg_fifo_ctrl.sv
// Purpose: turns the 32-entry instruction register into an in-order queue fed by two round-robin producers.
// Latency: accept -> load_en one cycle later; entry is committed (count, cons_valid) one cycle after that.
// Backpressure: readies drop when committed + in-flight entries reach DEPTH or during flush; consumer pops via valid/ready.
module instr_reg_fifo_ctrl #(
    parameter int OPC_W     = 4,
    parameter int OPERAND_W = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 p0_valid,
    output logic                 p0_ready,
    input  logic [OPC_W-1:0]     p0_opcode,
    input  logic [OPERAND_W-1:0] p0_operand_a,
    input  logic [OPERAND_W-1:0] p0_operand_b,
    input  logic                 p1_valid,
    output logic                 p1_ready,
    input  logic [OPC_W-1:0]     p1_opcode,
    input  logic [OPERAND_W-1:0] p1_operand_a,
    input  logic [OPERAND_W-1:0] p1_operand_b,
    output logic                 cons_valid,
    input  logic                 cons_ready,
    output logic                 load_en,
    output logic [ADDR_W-1:0]    write_pointer,
    output logic [OPC_W-1:0]     opcode,
    output logic [OPERAND_W-1:0] operand_a,
    output logic [OPERAND_W-1:0] operand_b,
    output logic [ADDR_W-1:0]    read_pointer,
    output logic [ADDR_W:0]      count,
    output logic                 full
);

    localparam int DEPTH = 1 << ADDR_W;

    logic                 load_en_q, load_en_d;
    logic [ADDR_W-1:0]    write_pointer_q, write_pointer_d;
    logic [OPC_W-1:0]     opcode_q, opcode_d;
    logic [OPERAND_W-1:0] operand_a_q, operand_a_d;
    logic [OPERAND_W-1:0] operand_b_q, operand_b_d;
    logic [ADDR_W-1:0]    head_q, head_d;
    logic [ADDR_W-1:0]    tail_q, tail_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 last_grant_q, last_grant_d;

    logic [ADDR_W+1:0]    occupancy;
    logic                 full_c;
    logic                 allow;
    logic                 p1_wins;
    logic                 acc0;
    logic                 acc1;
    logic                 accept;
    logic                 cons_valid_c;
    logic                 pop;

    // Slot accounting, round-robin arbitration and consumer handshake.
    always_comb begin
        // The in-flight write already owns a slot, so it counts toward full.
        occupancy    = {1'b0, count_q} + (ADDR_W+2)'(load_en_q);
        full_c       = (occupancy == (ADDR_W+2)'(DEPTH));
        allow        = !full_c && !flush;
        // On a tie the producer that did not win last time is granted.
        p1_wins      = p1_valid && (!p0_valid || !last_grant_q);
        p0_ready     = allow && !p1_wins;
        p1_ready     = allow && p1_wins;
        acc0         = p0_valid && p0_ready;
        acc1         = p1_valid && p1_ready;
        accept       = acc0 || acc1;
        cons_valid_c = (count_q != '0) && !flush;
        pop          = cons_valid_c && cons_ready;
    end

    // Next-state: write staging, pointer advance, occupancy and flush clear.
    always_comb begin
        load_en_d       = 1'b0;
        write_pointer_d = write_pointer_q;
        opcode_d        = opcode_q;
        operand_a_d     = operand_a_q;
        operand_b_d     = operand_b_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        last_grant_d    = last_grant_q;

        if (accept) begin
            load_en_d       = 1'b1;
            write_pointer_d = tail_q;
            tail_d          = tail_q + ADDR_W'(1);
            last_grant_d    = acc1;
            if (acc1) begin
                opcode_d    = p1_opcode;
                operand_a_d = p1_operand_a;
                operand_b_d = p1_operand_b;
            end else begin
                opcode_d    = p0_opcode;
                operand_a_d = p0_operand_a;
                operand_b_d = p0_operand_b;
            end
        end

        if (pop) begin
            head_d = head_q + ADDR_W'(1);
        end

        // An entry becomes committed the cycle the register captures it.
        case ({load_en_q, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // Flush drops everything queued and in flight but keeps arbitration history.
        if (flush) begin
            load_en_d = 1'b0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end
    end

    // State registers; reset wins over flush and any handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_en_q       <= 1'b0;
            write_pointer_q <= '0;
            opcode_q        <= '0;
            operand_a_q     <= '0;
            operand_b_q     <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            last_grant_q    <= 1'b1;
        end else begin
            load_en_q       <= load_en_d;
            write_pointer_q <= write_pointer_d;
            opcode_q        <= opcode_d;
            operand_a_q     <= operand_a_d;
            operand_b_q     <= operand_b_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            last_grant_q    <= last_grant_d;
        end
    end

    assign cons_valid    = cons_valid_c;
    assign full          = full_c;
    assign load_en       = load_en_q;
    assign write_pointer = write_pointer_q;
    assign opcode        = opcode_q;
    assign operand_a     = operand_a_q;
    assign operand_b     = operand_b_q;
    assign read_pointer  = head_q;
    assign count         = count_q;

endmodule
